// File: rtl/isqrt_pkg.sv
// isqrt_pkg: widths, per-iteration pipeline state and a reference square root.
package isqrt_pkg;
    localparam int ISQRT_X_W  = 32;
    localparam int ISQRT_Y_W  = 16;
    localparam int ISQRT_ITER = 16;

    typedef struct packed {
        logic [31:0] rem;
        logic [31:0] root;
    } isqrt_state_t;

    // Bitwise search for the largest r with r*r <= x; for benches.
    function automatic logic [ISQRT_Y_W-1:0] isqrt_ref(input logic [ISQRT_X_W-1:0] x);
        logic [ISQRT_Y_W-1:0] r;
        logic [ISQRT_Y_W-1:0] c;
        r = '0;
        for (int b = ISQRT_Y_W - 1; b >= 0; b--) begin
            c = r | (ISQRT_Y_W'(1) << b);
            if (ISQRT_X_W'(c) * ISQRT_X_W'(c) <= x) r = c;
        end
        return r;
    endfunction
endpackage

// File: rtl/isqrt_iter.sv
// isqrt_iter: one combinational digit iteration K of the restoring square root.
module isqrt_iter
    import isqrt_pkg::*;
#(
    parameter int K = 0
) (
    input  isqrt_state_t s_i,
    output isqrt_state_t s_o
);
    localparam logic [31:0] BIT = 32'd1 << (30 - 2 * K);

    logic [31:0] trial;
    logic        ge;

    always_comb begin
        trial     = s_i.root + BIT;
        ge        = s_i.rem >= trial;
        s_o.rem   = ge ? s_i.rem - trial : s_i.rem;
        s_o.root  = ge ? (s_i.root >> 1) + BIT : s_i.root >> 1;
    end
endmodule

// File: rtl/isqrt_pipe.sv
// isqrt_pipe: fixed-latency pipelined y = floor(sqrt(x)), one argument per clock.
// ISQRT_PIPE_OCCUPANCY_EN adds an in-flight entry counter output.
module isqrt_pipe
    import isqrt_pkg::*;
#(
    parameter  int ITER_PER_STAGE = 1,
    localparam int STAGES         = ISQRT_ITER / ITER_PER_STAGE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          x_vld,
    input  logic [ISQRT_X_W-1:0]          x,
    output logic                          y_vld,
    output logic [ISQRT_Y_W-1:0]          y
`ifdef ISQRT_PIPE_OCCUPANCY_EN
    ,
    output logic [$clog2(STAGES+1)-1:0]   occupancy
`endif
);
    if (ITER_PER_STAGE != 1 && ITER_PER_STAGE != 2 && ITER_PER_STAGE != 4 &&
        ITER_PER_STAGE != 8 && ITER_PER_STAGE != 16) begin : g_bad_cfg
        $error("isqrt_pipe: ITER_PER_STAGE must be 1, 2, 4, 8 or 16");
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        isqrt_state_t chain [ITER_PER_STAGE+1];
        isqrt_state_t st_q;
        isqrt_state_t st_d;
        logic         vld_q;
        logic         vin;

        if (s == 0) begin : g_head
            assign chain[0] = '{rem: x, root: '0};
            assign vin      = x_vld;
        end else begin : g_body
            assign chain[0] = g_stage[s-1].st_q;
            assign vin      = g_stage[s-1].vld_q;
        end

        for (genvar i = 0; i < ITER_PER_STAGE; i++) begin : g_iter
            isqrt_iter #(.K(s * ITER_PER_STAGE + i)) u_iter (
                .s_i(chain[i]),
                .s_o(chain[i+1])
            );
        end

        // Data only moves with a valid token, bubbles leave the register quiet.
        assign st_d = vin ? chain[ITER_PER_STAGE] : st_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st_q  <= '0;
                vld_q <= 1'b0;
            end else begin
                st_q  <= st_d;
                vld_q <= vin;
            end
        end
    end

    assign y_vld = g_stage[STAGES-1].vld_q;
    assign y     = g_stage[STAGES-1].st_q.root[ISQRT_Y_W-1:0];

    // Remainder and upper root bits are dead after the final iteration.
    logic unused_tail;
    assign unused_tail = ^{g_stage[STAGES-1].st_q.rem, g_stage[STAGES-1].st_q.root[31:ISQRT_Y_W]};

`ifdef ISQRT_PIPE_OCCUPANCY_EN
    localparam int OW = $clog2(STAGES + 1);

    logic [OW-1:0] occ_q;
    logic [OW-1:0] occ_d;

    assign occ_d = occ_q + OW'(x_vld) - OW'(y_vld);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) occ_q <= '0;
        else     occ_q <= occ_d;
    end

    assign occupancy = occ_q;
`endif
endmodule

// File: tb/tb_isqrt_pipe.sv
// tb_isqrt_pipe: drives all legal ITER_PER_STAGE variants in parallel and checks
// them against a per-cycle input history and a floating-point based square root.
module tb_isqrt_pipe;
    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        x_vld = 1'b0;
    logic [31:0] x     = '0;

    logic        yv [5];
    logic [15:0] yy [5];

    int n_chk  = 0;
    int n_fail = 0;
    int ec     = 0;
    bit          hv [0:32767];
    logic [31:0] hx [0:32767];

    logic [31:0] sx [$];
    bit          sv [$];
    logic [15:0] se [$];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_sqrt(input logic [31:0] v);
        real    rv;
        longint r;
        longint lv;
        rv = v;
        lv = {32'b0, v};
        r  = longint'($rtoi($sqrt(rv)));
        while (r * r > lv) r--;
        while ((r + 1) * (r + 1) <= lv) r++;
        return 16'(r);
    endfunction

    // History of what each clock edge accepted; a reset wipes everything in flight.
    always @(posedge clk) begin
        hv[ec] = !rst && x_vld;
        hx[ec] = x;
        ec++;
    end

    always @(posedge rst) for (int i = 0; i < ec; i++) hv[i] = 1'b0;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int IPS = 1 << g;
        localparam int S   = 16 / IPS;
        int src;
        bit ev;
`ifdef ISQRT_PIPE_OCCUPANCY_EN
        logic [$clog2(S+1)-1:0] occ;
        int cnt;
`endif

        isqrt_pipe #(.ITER_PER_STAGE(IPS)) u_dut (
            .clk(clk),
            .rst(rst),
            .x_vld(x_vld),
            .x(x),
            .y_vld(yv[g]),
            .y(yy[g])
`ifdef ISQRT_PIPE_OCCUPANCY_EN
            ,
            .occupancy(occ)
`endif
        );

        always @(negedge clk) if (ec > 0) begin
            src = ec - S;
            ev  = src >= 0 && hv[src];
            check($sformatf("ips%0d_vld", IPS), 32'(yv[g]), 32'(ev));
            if (ev) check($sformatf("ips%0d_y x=%0h", IPS, hx[src]), 32'(yy[g]), 32'(model_sqrt(hx[src])));
`ifdef ISQRT_PIPE_OCCUPANCY_EN
            cnt = 0;
            for (int i = (ec > S ? ec - S : 0); i < ec; i++) cnt += int'(hv[i]);
            check($sformatf("ips%0d_occ", IPS), 32'(occ), 32'(cnt));
`endif
        end
    end

    // Plays sx/sv into the 16-stage variant and checks se on the matching output cycles.
    task automatic run_seq(input string tag);
        int n;
        n = sx.size();
        for (int i = 0; i < n + 16; i++) begin
            @(negedge clk);
            if (i >= 16) begin
                check($sformatf("%s_vld%0d", tag, i - 16), 32'(yv[0]), 32'(sv[i-16]));
                if (sv[i-16]) check($sformatf("%s_y%0d", tag, i - 16), 32'(yy[0]), 32'(se[i-16]));
            end
            if (i < n) begin
                x_vld = sv[i];
                x     = sx[i];
            end else begin
                x_vld = 1'b0;
                x     = '0;
            end
        end
    endtask

    initial begin
        int pulses;
        logic [31:0] corners [7];
        corners = '{32'd0, 32'd1, 32'd3, 32'd4, 32'hFFFF_FFFF, 32'hFFFE_0001, 32'hFFFE_0000};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Fill the pipes, then reset asynchronously between edges.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            x_vld = 1'b1;
            x     = 32'd1_000_000 + 32'(i);
        end
        @(negedge clk);
        x_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            check($sformatf("async_rst_vld%0d", g), 32'(yv[g]), 32'd0);
            check($sformatf("async_rst_y%0d", g), 32'(yy[g]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("post_rst_vld", 32'(yv[0]), 32'd0);
            check("post_rst_y", 32'(yy[0]), 32'd0);
        end

        sx = '{32'd0, 32'd1, 32'd3, 32'd4, 32'hFFFF_FFFF, 32'hFFFE_0001, 32'hFFFE_0000};
        sv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        se = '{16'd0, 16'd1, 16'd1, 16'd2, 16'hFFFF, 16'hFFFF, 16'hFFFE};
        run_seq("corner");

        sx = '{32'd16, 32'd25, 32'd9};
        sv = '{1'b1, 1'b1, 1'b1};
        se = '{16'd4, 16'd5, 16'd3};
        run_seq("triplet");

        sx = '{32'd100, 32'd7, 32'd8, 32'hFFFE_0001};
        sv = '{1'b1, 1'b0, 1'b0, 1'b1};
        se = '{16'd10, 16'd0, 16'd0, 16'hFFFF};
        run_seq("bubble");

        // Three values in flight, then a one-cycle reset must swallow them all.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            x_vld = 1'b1;
            x     = 32'd400 * 32'(i + 1);
        end
        @(negedge clk);
        x_vld = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pulses += int'(yv[0]);
        end
        check("midrst_pulses", 32'(pulses), 32'd0);

        sx = '{32'd49};
        sv = '{1'b1};
        se = '{16'd7};
        run_seq("after_rst");

        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            x_vld = $urandom_range(0, 3) != 0;
            x     = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 6)] : $urandom;
        end
        @(negedge clk);
        x_vld = 1'b0;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
